// File: rtl/snake_pixel_renderer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : snake_pixel_renderer                                          |
// | Desc   : Playfield cell RAM to 1-bit RGB colour stage with sync delay. |
// |          Optional macro GRID_LINES_EN draws blue cell grid lines.      |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module snake_pixel_renderer #(
  parameter int GRID_W     = 40,
  parameter int GRID_H     = 30,
  parameter int CELL_SHIFT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       activevideo_in,
  input  logic [9:0] x_px,
  input  logic [9:0] y_px,
  input  logic       wr_en,
  input  logic [5:0] wr_x,
  input  logic [4:0] wr_y,
  input  logic [1:0] wr_data,
  output logic       hsync,
  output logic       vsync,
  output logic       red,
  output logic       green,
  output logic       blue,
  output logic       frame_tick,
  output logic       busy
);

  localparam int          CELLS     = GRID_W * GRID_H;
  localparam logic [10:0] LAST_ADDR = 11'(CELLS - 1);
  localparam logic [5:0]  WR_COLS   = 6'(GRID_W);
  localparam logic [4:0]  WR_ROWS   = 5'(GRID_H);
  localparam logic [9:0]  PX_COLS   = 10'(GRID_W);
  localparam logic [9:0]  PX_ROWS   = 10'(GRID_H);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [10:0] clr_cnt_q, clr_cnt_d;
  logic        mem_we;
  logic [10:0] mem_waddr;
  logic [1:0]  mem_wdata;
  logic [1:0]  mem_q [CELLS];
  logic [1:0]  rdata_q;

  logic [3:0]  hs_pipe_q;
  logic [3:0]  vs_pipe_q;
  logic [2:0]  act_pipe_q;
  logic [10:0] addr_q;
  logic [2:0]  rgb_q, rgb_d;
  logic        tick_q;

  logic [10:0] wr_addr;
  logic [9:0]  px_col, px_row;
  logic        px_in_grid;
  logic [10:0] px_addr;

  // row*40 as shift-add; the address map assumes a 40-wide playfield
  assign wr_addr = ({6'd0, wr_y} << 5) + ({6'd0, wr_y} << 3) + {5'd0, wr_x};

  assign px_col     = x_px >> CELL_SHIFT;
  assign px_row     = y_px >> CELL_SHIFT;
  assign px_in_grid = (px_col < PX_COLS) && (px_row < PX_ROWS);
  assign px_addr    = px_in_grid ?
                      (({1'b0, px_row} << 5) + ({1'b0, px_row} << 3) + {1'b0, px_col}) :
                      11'd0;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = 11'd0;
    mem_wdata = 2'd0;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = ST_RUN;
          clr_cnt_d = 11'd0;
        end else begin
          clr_cnt_d = clr_cnt_q + 11'd1;
        end
      end
      default: begin
        if (wr_en && (wr_x < WR_COLS) && (wr_y < WR_ROWS)) begin
          mem_we    = 1'b1;
          mem_waddr = wr_addr;
          mem_wdata = wr_data;
        end
      end
    endcase
  end

  // RAM array and its read register carry no reset so they map onto block RAM
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
    rdata_q <= mem_q[addr_q];
  end

`ifdef GRID_LINES_EN
  logic [1:0] edge_pipe_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      edge_pipe_q <= 2'b00;
    end else begin
      edge_pipe_q <= {edge_pipe_q[0],
                      (x_px[CELL_SHIFT-1:0] == '0) || (y_px[CELL_SHIFT-1:0] == '0)};
    end
  end
`endif

  always_comb begin
    rgb_d = 3'b000;
    if (act_pipe_q[2] && (state_q == ST_RUN)) begin
      case (rdata_q)
        2'd1:    rgb_d = 3'b010;
        2'd2:    rgb_d = 3'b110;
        2'd3:    rgb_d = 3'b100;
        default: begin
`ifdef GRID_LINES_EN
          rgb_d = edge_pipe_q[1] ? 3'b001 : 3'b000;
`else
          rgb_d = 3'b000;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= 11'd0;
      hs_pipe_q  <= 4'hF;
      vs_pipe_q  <= 4'hF;
      act_pipe_q <= 3'b000;
      addr_q     <= 11'd0;
      rgb_q      <= 3'b000;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      hs_pipe_q  <= {hs_pipe_q[2:0], hsync_in};
      vs_pipe_q  <= {vs_pipe_q[2:0], vsync_in};
      act_pipe_q <= {act_pipe_q[1:0], activevideo_in};
      addr_q     <= px_addr;
      rgb_q      <= rgb_d;
      // falling edge of the stage-0 vsync copy
      tick_q     <= vs_pipe_q[1] & ~vs_pipe_q[0];
    end
  end

  assign hsync              = hs_pipe_q[3];
  assign vsync              = vs_pipe_q[3];
  assign {red, green, blue} = rgb_q;
  assign frame_tick         = tick_q;
  assign busy               = (state_q == ST_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_snake_pixel_renderer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_snake_pixel_renderer                                       |
// | Desc   : Self-checking bench for snake_pixel_renderer (GRID_LINES_EN   |
// |          aware): directed vectors, sync pulses, random model stream.   |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module tb_snake_pixel_renderer;

  localparam int NP = 200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hsync_in, vsync_in, activevideo_in;
  logic [9:0] x_px, y_px;
  logic       wr_en;
  logic [5:0] wr_x;
  logic [4:0] wr_y;
  logic [1:0] wr_data;
  logic       hsync, vsync, red, green, blue, frame_tick, busy;

  always #5 clk = ~clk;

  snake_pixel_renderer dut (
    .clk(clk), .rst_n(rst_n),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .activevideo_in(activevideo_in),
    .x_px(x_px), .y_px(y_px),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
    .frame_tick(frame_tick), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int mem_m [1200];

  typedef struct {
    int x;
    int y;
    int d;
  } wr_t;

  typedef struct {
    int x;
    int y;
    int act;
    int exp_plain;
    int exp_grid;
  } pix_t;

  wr_t  wrs [4];
  pix_t vec [10];

  int px [NP];
  int py [NP];
  int pa [NP+1];
  int hs [NP];
  int cx [$];
  int cy [$];

  task automatic check(input string nm, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // colour rule: type map, blanking, optional grid lines on empty cells
  function automatic int exp_colour(input int x, input int y, input int act);
    int t;
    if (act == 0) return 0;
    t = mem_m[(y / 16) * 40 + (x / 16)];
    case (t)
      1: return 3'b010;
      2: return 3'b110;
      3: return 3'b100;
      default: begin
`ifdef GRID_LINES_EN
        return ((x % 16 == 0) || (y % 16 == 0)) ? 3'b001 : 3'b000;
`else
        return 0;
`endif
      end
    endcase
  endfunction

  task automatic cell_write(input int x, input int y, input int d);
    wr_en = 1'b1; wr_x = 6'(x); wr_y = 5'(y); wr_data = 2'(d);
    if (x < 40 && y < 30) mem_m[y * 40 + x] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic show_pixel(input int x, input int y, input int a);
    x_px = 10'(x); y_px = 10'(y); activevideo_in = a[0];
    repeat (5) @(negedge clk);
  endtask

  // release reset and count cycles with busy high; the model RAM is cleared
  task automatic run_clear(input bit poke_mid);
    int cnt = 0;
    int bad = 0;
    rst_n = 1'b1;
    while (busy && cnt < 2000) begin
      cnt++;
      if (hsync !== 1'b1 || vsync !== 1'b1 || {red, green, blue} !== 3'b000) bad++;
      if (poke_mid && cnt == 600) begin
        wr_en = 1'b1; wr_x = 6'd1; wr_y = 5'd0; wr_data = 2'd1;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("clear_busy_cycles", cnt, 1200);
    check("clear_outputs_idle", bad, 0);
    foreach (mem_m[i]) mem_m[i] = 0;
  endtask

  task automatic sync_pulse(input bit is_v);
    int first_low = -1;
    int n_low = 0;
    int first_tick = -1;
    int n_tick = 0;
    logic s;
    for (int i = 0; i < 50; i++) begin
      s = is_v ? vsync : hsync;
      if (!s) begin
        n_low++;
        if (first_low < 0) first_low = i;
      end
      if (frame_tick) begin
        n_tick++;
        if (first_tick < 0) first_tick = i;
      end
      if (is_v) vsync_in = (i < 40) ? 1'b0 : 1'b1;
      else      hsync_in = (i < 40) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    check(is_v ? "vsync_first_low" : "hsync_first_low", first_low, 4);
    check(is_v ? "vsync_low_len" : "hsync_low_len", n_low, 40);
    if (is_v) begin
      check("tick_count", n_tick, 1);
      check("tick_delay", first_tick, 2);
    end else begin
      check("tick_none_on_hsync", n_tick, 0);
    end
  endtask

  initial begin
    int j;
    wrs[0] = '{5, 3, 3};
    wrs[1] = '{40, 0, 1};
    wrs[2] = '{0, 30, 1};
    wrs[3] = '{39, 29, 2};

    vec[0] = '{85, 53, 1, 3'b100, 3'b100};
    vec[1] = '{80, 48, 1, 3'b100, 3'b100};
    vec[2] = '{96, 53, 1, 3'b000, 3'b001};
    vec[3] = '{8, 8, 1, 3'b000, 3'b000};
    vec[4] = '{0, 8, 1, 3'b000, 3'b001};
    vec[5] = '{8, 24, 1, 3'b000, 3'b000};
    vec[6] = '{24, 8, 1, 3'b000, 3'b000};
    vec[7] = '{639, 479, 1, 3'b110, 3'b110};
    vec[8] = '{632, 472, 1, 3'b110, 3'b110};
    vec[9] = '{639, 479, 0, 3'b000, 3'b000};

    rst_n = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; activevideo_in = 1'b0;
    x_px = '0; y_px = '0; wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
    repeat (3) @(negedge clk);

    check("rst_busy", busy, 1);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_rgb", {red, green, blue}, 0);
    check("rst_tick", frame_tick, 0);

    activevideo_in = 1'b1;
    run_clear(1'b1);
    activevideo_in = 1'b0;
    @(negedge clk);

    foreach (wrs[i]) cell_write(wrs[i].x, wrs[i].y, wrs[i].d);
    @(negedge clk);

    foreach (vec[i]) begin
      show_pixel(vec[i].x, vec[i].y, vec[i].act);
`ifdef GRID_LINES_EN
      check($sformatf("pix[%0d]", i), {red, green, blue}, vec[i].exp_grid);
`else
      check($sformatf("pix[%0d]", i), {red, green, blue}, vec[i].exp_plain);
`endif
    end
    activevideo_in = 1'b0;

    sync_pulse(1'b0);
    sync_pulse(1'b1);

    for (int r = 0; r < 3; r++) begin
      cx.delete(); cy.delete();
      for (int k = 0; k < 40; k++) begin
        int wx, wy, wd;
        wx = $urandom_range(0, 45);
        wy = $urandom_range(0, 31);
        wd = $urandom_range(0, 3);
        if (wx < 40 && wy < 30) begin
          cx.push_back(wx); cy.push_back(wy);
        end
        cell_write(wx, wy, wd);
      end
      for (int i = 0; i < NP; i++) begin
        hs[i] = $urandom_range(0, 1);
        if ($urandom_range(0, 7) == 0) begin
          pa[i] = 0;
          px[i] = $urandom_range(640, 799);
          py[i] = $urandom_range(0, 524);
        end else begin
          pa[i] = ($urandom_range(0, 9) != 0) ? 1 : 0;
          if (cx.size() > 0 && $urandom_range(0, 1) == 1) begin
            j = $urandom_range(0, cx.size() - 1);
            px[i] = cx[j] * 16 + $urandom_range(0, 15);
            py[i] = cy[j] * 16 + $urandom_range(0, 15);
          end else begin
            px[i] = $urandom_range(0, 639);
            py[i] = $urandom_range(0, 479);
          end
        end
      end
      pa[NP] = 0;
      activevideo_in = pa[0][0];
      @(negedge clk);
      for (int i = 0; i < NP + 4; i++) begin
        if (i >= 3 && i - 3 < NP)
          check("rand_rgb", {red, green, blue}, exp_colour(px[i-3], py[i-3], pa[i-3]));
        if (i >= 4)
          check("rand_hsync", hsync, hs[i-4]);
        if (i < NP) begin
          x_px = 10'(px[i]); y_px = 10'(py[i]);
          activevideo_in = pa[i+1][0]; hsync_in = hs[i][0];
        end else begin
          activevideo_in = 1'b0; hsync_in = 1'b1;
        end
        @(negedge clk);
      end
    end

    // reset mid-frame with a lit pixel and low hsync in flight
    cell_write(5, 3, 3);
    hsync_in = 1'b0;
    show_pixel(85, 53, 1);
    check("pre_rst_rgb", {red, green, blue}, 3'b100);
    check("pre_rst_hsync", hsync, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_hsync", hsync, 1);
    check("mid_rst_rgb", {red, green, blue}, 0);
    check("mid_rst_busy", busy, 1);
    check("mid_rst_tick", frame_tick, 0);
    hsync_in = 1'b1;
    @(negedge clk);
    run_clear(1'b0);
    show_pixel(85, 53, 1);
    check("post_clear_5_3", {red, green, blue}, 0);
    show_pixel(639, 479, 1);
    check("post_clear_39_29", {red, green, blue}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
